// File: rtl/gf2m_digit_mul_ctrl.sv
// ---------------------------------------------------------------------------
// gf2m_digit_mul_ctrl
//
// Digit-serial GF(2^M) multiplier with start/busy/done handshake.
// Operands are latched on an accepted start. B is then consumed D bits per
// cycle, MSB-first, through a chain of D reduction rows that update the
// partial result T. After NUM_DIGITS cycles the product C = A*B mod f(x)
// is placed on c_out together with a one-cycle done pulse.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  synchronous active-low reset
//   start  in   1  request, sampled only while idle
//   a_in   in   M  multiplicand A, captured on the accepted start edge
//   b_in   in   M  multiplier B, captured on the accepted start edge
//   busy   out  1  high while a multiply is in progress
//   done   out  1  one-cycle pulse, c_out valid from this cycle
//   c_out  out  M  result A*B mod f, held until the next done
// ---------------------------------------------------------------------------
module gf2m_digit_mul_ctrl #(
   parameter int unsigned  M = 163,
   parameter int unsigned  D = 32,
   parameter logic [M-1:0] G = 163'h0C9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [M-1:0] a_in,
   input  logic [M-1:0] b_in,
   output logic         busy,
   output logic         done,
   output logic [M-1:0] c_out
);

   localparam int unsigned   NUM_DIGITS = (M + D - 1) / D;
   localparam int unsigned   BW         = NUM_DIGITS * D;
   localparam int unsigned   CW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] LAST_CNT   = CW'(NUM_DIGITS - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic           load;
   logic           last;

   logic [M-1:0]   a_reg;
   logic [BW-1:0]  b_reg;   // B zero-padded at the MSB end to whole digits
   logic [M-1:0]   t_reg;
   logic [M-1:0]   t_step;
   logic [CW-1:0]  cnt;

   // One digit step: D bit-rows, digit bit D-1 first. Each row is
   // T <- T*x + d*A, with the x^M overflow folded back in through G.
   function automatic logic [M-1:0] step_rows(input logic [M-1:0] t,
                                               input logic [M-1:0] a,
                                               input logic [D-1:0] d);
      logic [M-1:0] r;
      logic         msb;
      // NOTE: blocking assignments here are intentional -- each row must see
      // the previous row's result within the same evaluation.
      r = t;
      for (int i = int'(D) - 1; i >= 0; i--) begin
         msb = r[M-1];
         r   = {r[M-2:0], 1'b0} ^ (a & {M{d[i]}}) ^ (G & {M{msb}});
      end
      return r;
   endfunction

   assign t_step = step_rows(t_reg, a_reg, b_reg[BW-1 -: D]);

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples values from before the edge.
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and control strobes.
   always_comb begin
      // NOTE: defaults first so every path assigns every output; without
      // them an incomplete branch would infer a latch.
      state_nxt = state;
      load      = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (cnt == LAST_CNT) begin
               last      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath and handshake outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_reg <= '0;
         b_reg <= '0;
         t_reg <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         c_out <= '0;
      end else begin
         done <= last;
         if (load) begin
            a_reg <= a_in;
            b_reg <= BW'(b_in);
            t_reg <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
         end else if (state == RUN) begin
            t_reg <= t_step;
            b_reg <= b_reg << D;
            cnt   <= cnt + 1'b1;
            if (last) begin
               c_out <= t_step;
               busy  <= 1'b0;
            end
         end
      end
   end

endmodule
